// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 shift-and-add multiplier. Start to done takes 5 cycles; start is ignored while busy.
// Optional MULT_ZERO_SKIP_EN: zero operands go straight to DONE with latency 1.
// No backpressure: done is a one-cycle pulse and product holds until the next accepted start.

module adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum_out,
  output logic       c_out
);
  assign {c_out, sum_out} = {1'b0, a} + {1'b0, b};
endmodule

module shift_add_mult_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] mcand;
  logic [7:0] acc;
  logic [7:0] acc_next;
  logic [1:0] step_cnt;
  logic [3:0] sum_out;
  logic       c_out;

  adder_4bits u_adder (
    .a       (acc[7:4]),
    .b       (mcand),
    .sum_out (sum_out),
    .c_out   (c_out)
  );

  // High nibble accumulates partial products; low nibble shifts out the multiplier bits.
  always_comb begin
    acc_next = {1'b0, acc[7:1]};
    if (acc[0]) begin
      acc_next = {c_out, sum_out, acc[3:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mcand    <= 4'h0;
      acc      <= 8'h00;
      step_cnt <= 2'd0;
      product  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand    <= x;
            acc      <= {4'h0, y};
            step_cnt <= 2'd0;
`ifdef MULT_ZERO_SKIP_EN
            if ((x == 4'h0) || (y == 4'h0)) begin
              product <= 8'h00;
              state   <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
`else
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          if (step_cnt == 2'd3) begin
            product <= acc_next;
            state   <= ST_DONE;
          end else begin
            step_cnt <= step_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed self-checking bench for shift_add_mult_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] x;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int vectors;
  int miscompares;
  int done_cnt;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 5;
`endif

  shift_add_mult_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done cycles are counted at the edge that closes each done cycle.
  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the block idle; returns at the falling edge of the done cycle.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p,
                        input int exp_lat, input string tag, input bit chk_busy);
    int lat;
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      if (chk_busy) check({tag, "_busy_calc"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    if (chk_busy) check({tag, "_busy_done"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int dc0;
    vectors = 0;
    miscompares = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    x = 4'h0;
    y = 4'h0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 15*15: busy across 5 cycles, done at start+5
    run_op(4'd15, 4'd15, 8'hE1, 5, "m15x15", 1'b1);
    @(negedge clk);
    check("m15x15_done_pulse", 32'(done), 32'd0);
    check("m15x15_busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("m15x15_product_hold", 32'(product), 32'hE1);

    // 10*11 with operands changed and start reasserted during CALC
    dc0 = done_cnt;
    x = 4'd10;
    y = 4'd11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 4'd3;
    y = 4'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("ign_start_done_count", done_cnt - dc0, 1);
    check("ign_start_product", 32'(product), 32'h6E);
    check("ign_start_busy_low", 32'(busy), 32'd0);

    // zero operand path
    run_op(4'd0, 4'd9, 8'h00, ZERO_LAT, "m0x9", 1'b1);
    @(negedge clk);
    check("m0x9_done_pulse", 32'(done), 32'd0);

    run_op(4'd12, 4'd5, 8'h3C, 5, "m12x5", 1'b0);
    @(negedge clk);

    // reset in second CALC cycle of 7*6
    dc0 = done_cnt;
    x = 4'd7;
    y = 4'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_product", 32'(product), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_done", done_cnt - dc0, 0);
    run_op(4'd7, 4'd6, 8'h2A, 5, "m7x6_after_abort", 1'b0);
    @(negedge clk);
    check("abort_total_dones", done_cnt - dc0, 1);

    // exhaustive back-to-back sweep, start in first IDLE cycle after done
    dc0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 8'(i * j),
               ((i == 0) || (j == 0)) ? ZERO_LAT : 5, "sweep", 1'b0);
        @(negedge clk);
      end
    end
    check("sweep_done_count", done_cnt - dc0, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameters: none; operand width fixed at 4 bits, product width at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 x  input  4  multiplicand, unsigned; captured when start is accepted.
REQ-006 y  input  4  multiplier, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while in CALC or DONE.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  8  unsigned x*y; holds its last value until the next accepted start.

Function
REQ-010 The block SHALL be a sequential shift-and-add multiplier.
REQ-011 It SHALL use exactly one adder_4bits instance as its sole adder.
REQ-012 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-013 IDLE with start=1 SHALL accept the request on that edge:
  - capture x into the multiplicand register (mcand) and y into the low nibble of the accumulator (acc[3:0]);
  - clear acc[7:4] and the 2-bit step counter;
  - go to CALC.
REQ-014 Each CALC cycle, with acc[0]=1, SHALL add acc[7:4] + mcand in adder_4bits.
  - Then acc <= {c_out, sum_out, acc[3:1]}.
REQ-015 Each CALC cycle, with acc[0]=0, SHALL shift only: acc <= {1'b0, acc[7:1]}.
REQ-016 CALC SHALL last exactly 4 cycles, counter 0..3.
  - Counter value 3 SHALL transition to DONE.
  - The counter SHALL never wrap inside an operation.
REQ-017 DONE SHALL:
  - last one cycle;
  - assert done=1;
  - drive product=acc;
  - return to IDLE unconditionally.
REQ-018 Latency: start accepted at edge T SHALL give done=1 in the cycle after edge T+4, i.e. 5 cycles start-to-done.
REQ-019 start SHALL be ignored in CALC and DONE.
  - No operand capture; the in-flight result is unaffected.
REQ-020 Back-to-back: start=1 in the IDLE cycle immediately after DONE SHALL be accepted; maximum throughput is one product per 6 cycles.
REQ-021 x/y changes after acceptance SHALL NOT affect the result.
REQ-022 product SHALL update only on entry to DONE.
  - Between operations it SHALL retain the last result.
REQ-023 The result SHALL equal the full 8-bit product for all 256 operand pairs, with no overflow (max 15*15=225).

Reset
REQ-024 rst_n=0 SHALL asynchronously force:
  - state=IDLE;
  - busy=0, done=0, product=8'h00;
  - acc, mcand and counter to 0.
REQ-025 Reset mid-operation SHALL abort it without a done pulse.
  - After release, the block SHALL be idle and accept a new start on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro MULT_ZERO_SKIP_EN: when defined, a start accepted with x==0 or y==0 SHALL go directly IDLE->DONE.
  - product=8'h00, done one cycle after acceptance (latency 1); CALC is skipped.
REQ-027 Without MULT_ZERO_SKIP_EN, zero operands SHALL take the full 4-cycle CALC path (latency 5) and still yield 8'h00.
REQ-028 Nonzero-operand behaviour SHALL be identical with and without the macro.

Verification
REQ-029 x=15, y=15, start pulse in IDLE:
  - busy=1 for 5 cycles;
  - done=1 exactly at start+5 with product=8'hE1 (225).
REQ-030 x=10, y=11, then x/y changed to 3/3 during CALC, and start reasserted in CALC:
  - product=8'h6E (110);
  - the second start is ignored (exactly one done pulse).
REQ-031 x=0, y=9:
  - with MULT_ZERO_SKIP_EN: done at start+1, product=8'h00;
  - without it: done at start+5, product=8'h00.
REQ-032 rst_n pulsed low in the 2nd CALC cycle of 7*6:
  - no done pulse; product=8'h00, busy=0 immediately;
  - a next start of 7*6 then yields 8'h2A at start+5.
REQ-033 Exhaustive 256-pair sweep, back-to-back starts issued in the first IDLE cycle after each done:
  - every product matches x*y;
  - one done per request.
